// File: rtl/cpu_bus_pkg.sv
// Shared widths and default timing constants for the CPU bus / interrupt /
// clock-enable glue block.
package cpu_bus_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 8;
  localparam int DEF_CLK_DIV     = 12;
  localparam int DEF_RST_HOLD    = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-flop synchronizer for an active-low asynchronous interrupt source,
// with an optional one-cycle falling-edge pulse on the synchronized level.
module int_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [STAGES-1:0] stage_p;

  // Shift the raw input through the chain; idle (deasserted) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_p <= '1;
    end else begin
      stage_p <= {stage_p[STAGES-2:0], d};
    end
  end

  assign q = stage_p[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic q_p;

      // Remember the previous synchronized level for edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_p <= 1'b1;
        end else begin
          q_p <= q;
        end
      end

      assign fall = q_p & ~q;
    end else begin : g_noedge
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_bus_int_clkgen.sv
// Glue between the 6502 core and its bus: CPU clock-enable divider, reset
// stretcher, NMI/IRQ conditioning and RAM steering with a read-data hold.
// Optional build macro CPU_CYCLE_CNT_EN adds o_CYCLE_CNT, a 32-bit count of
// CE pulses seen while the CPU is out of reset.
module cpu_bus_int_clkgen
  import cpu_bus_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  output logic              o_CPU_CE,
  output logic              o_CPU_RST_N,
  input  logic              i_NMI_SRC_N,
  input  logic              i_IRQ_SRC_N,
  output logic              o_NMI_N,
  output logic              o_IRQ_N,
  input  logic [ADDR_W-1:0] i_CPU_ADDR,
  input  logic [DATA_W-1:0] i_CPU_DATA,
  input  logic              i_CPU_R_WN,
  output logic [DATA_W-1:0] o_CPU_DATA,
  output logic [ADDR_W-1:0] o_MEM_ADDR,
  output logic [DATA_W-1:0] o_MEM_DATA,
  output logic              o_MEM_W_N,
  input  logic [DATA_W-1:0] i_MEM_Q
`ifdef CPU_CYCLE_CNT_EN
  ,
  output logic [31:0]       o_CYCLE_CNT
`endif
);

  localparam int CNT_W  = cnt_bits(CLK_DIV);
  localparam int HOLD_W = cnt_bits(RST_HOLD);

  logic              rel;
  logic [CNT_W-1:0]  div_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              ce_load;
  logic              nmi_lvl;
  logic              nmi_fall;
  logic              nmi_pend;
  logic              irq_lvl;
  logic              irq_fall_unused;

  // ce_load is true on the edge that raises o_CPU_CE; every "at CE" update
  // is taken on that same edge so it lines up with the visible CE cycle.
  assign ce_load = rel && (div_cnt == CNT_W'(CLK_DIV - 2));

  // Divider: the first edge after reset release only arms the counter.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      rel      <= 1'b0;
      div_cnt  <= '0;
      o_CPU_CE <= 1'b0;
    end else begin
      rel <= 1'b1;
      if (rel) begin
        div_cnt <= (div_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
      end
      o_CPU_CE <= ce_load;
    end
  end

  // Reset stretcher: release the CPU on the RST_HOLD-th CE pulse.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      hold_cnt    <= '0;
      o_CPU_RST_N <= 1'b0;
    end else if (ce_load && !o_CPU_RST_N) begin
      if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
        o_CPU_RST_N <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  int_sync #(
    .STAGES  (SYNC_STAGES),
    .EDGE_EN (1'b1)
  ) u_nmi_sync (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .d     (i_NMI_SRC_N),
    .q     (nmi_lvl),
    .fall  (nmi_fall)
  );

  int_sync #(
    .STAGES  (SYNC_STAGES),
    .EDGE_EN (1'b0)
  ) u_irq_sync (
    .clk   (i_CLK),
    .rst_n (i_RST_N),
    .d     (i_IRQ_SRC_N),
    .q     (irq_lvl),
    .fall  (irq_fall_unused)
  );

  // Interrupt outputs change only at CE; a fresh NMI edge beats the clear.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_NMI_N  <= 1'b1;
      o_IRQ_N  <= 1'b1;
      nmi_pend <= 1'b0;
    end else if (!o_CPU_RST_N) begin
      o_NMI_N  <= 1'b1;
      o_IRQ_N  <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      if (ce_load) begin
        o_NMI_N <= nmi_lvl & ~nmi_pend;
        o_IRQ_N <= irq_lvl;
      end
      if (nmi_fall) begin
        nmi_pend <= 1'b1;
      end else if (ce_load) begin
        nmi_pend <= 1'b0;
      end
    end
  end

  // Capture RAM read data one cycle before CE so it is steady during CE.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_CPU_DATA <= '0;
    end else if (ce_load) begin
      o_CPU_DATA <= i_MEM_Q;
    end
  end

  assign o_MEM_ADDR = i_CPU_ADDR;
  assign o_MEM_DATA = i_CPU_DATA;
  assign o_MEM_W_N  = ~(~i_CPU_R_WN & o_CPU_CE & o_CPU_RST_N);

`ifdef CPU_CYCLE_CNT_EN
  // Free-running count of CPU cycles executed out of reset.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      o_CYCLE_CNT <= '0;
    end else if (o_CPU_CE && o_CPU_RST_N) begin
      o_CYCLE_CNT <= o_CYCLE_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_bus_int_clkgen.sv
// Bench for cpu_bus_int_clkgen: directed scenarios plus randomized traffic,
// checked against a cycle-count based reference model and a RAM model.
module tb_cpu_bus_int_clkgen;

  localparam int D = 12;
  localparam int H = 8;
  localparam int S = 2;

  logic        i_CLK = 1'b0;
  logic        i_RST_N;
  logic        o_CPU_CE;
  logic        o_CPU_RST_N;
  logic        i_NMI_SRC_N;
  logic        i_IRQ_SRC_N;
  logic        o_NMI_N;
  logic        o_IRQ_N;
  logic [15:0] i_CPU_ADDR;
  logic [7:0]  i_CPU_DATA;
  logic        i_CPU_R_WN;
  logic [7:0]  o_CPU_DATA;
  logic [15:0] o_MEM_ADDR;
  logic [7:0]  o_MEM_DATA;
  logic        o_MEM_W_N;
  logic [7:0]  i_MEM_Q = 8'h00;

  int checks = 0;
  int passes = 0;

  cpu_bus_int_clkgen #(
    .CLK_DIV     (D),
    .RST_HOLD    (H),
    .SYNC_STAGES (S)
  ) dut (
    .i_CLK       (i_CLK),
    .i_RST_N     (i_RST_N),
    .o_CPU_CE    (o_CPU_CE),
    .o_CPU_RST_N (o_CPU_RST_N),
    .i_NMI_SRC_N (i_NMI_SRC_N),
    .i_IRQ_SRC_N (i_IRQ_SRC_N),
    .o_NMI_N     (o_NMI_N),
    .o_IRQ_N     (o_IRQ_N),
    .i_CPU_ADDR  (i_CPU_ADDR),
    .i_CPU_DATA  (i_CPU_DATA),
    .i_CPU_R_WN  (i_CPU_R_WN),
    .o_CPU_DATA  (o_CPU_DATA),
    .o_MEM_ADDR  (o_MEM_ADDR),
    .o_MEM_DATA  (o_MEM_DATA),
    .o_MEM_W_N   (o_MEM_W_N),
    .i_MEM_Q     (i_MEM_Q)
  );

  always #5 i_CLK = ~i_CLK;

  // Synchronous RAM model: one-cycle read latency, read-before-write.
  logic [7:0] mem [int];
  initial begin
    logic [7:0] q_n;
    forever begin
      @(posedge i_CLK);
      q_n = mem.exists(int'(o_MEM_ADDR)) ? mem[int'(o_MEM_ADDR)] : (o_MEM_ADDR[7:0] ^ 8'h5A);
      if (!o_MEM_W_N) mem[int'(o_MEM_ADDR)] = o_MEM_DATA;
      i_MEM_Q <= q_n;
    end
  end

  // Reference model. k = clock edges since reset release; CE is high in
  // every cycle k that is a positive multiple of D, the CPU leaves reset in
  // cycle D*H, synchronized levels are the source delayed by S samples.
  int         k;
  bit         m_ce, m_rst, m_nmi, m_irq, m_pend;
  logic [7:0] m_data;
  bit         nq[$];
  bit         iq[$];
  bit         nl, il, nprev;
  initial begin
    bit onl, oil, orst, opend, ofall;
    forever begin
      @(posedge i_CLK or negedge i_RST_N);
      if (!i_RST_N) begin
        k = 0; m_ce = 0; m_rst = 0; m_nmi = 1; m_irq = 1; m_pend = 0;
        m_data = 8'h00; nq.delete(); iq.delete(); nl = 1; il = 1; nprev = 1;
      end else begin
        onl = nl; oil = il; orst = m_rst; opend = m_pend;
        ofall = nprev & ~nl;
        k++;
        m_ce = (k % D) == 0;
        if (m_ce) m_data = i_MEM_Q;
        m_rst = (k >= D * H);
        if (!orst) begin
          m_nmi = 1; m_irq = 1; m_pend = 0;
        end else begin
          if (m_ce) begin
            m_nmi = onl & ~opend;
            m_irq = oil;
          end
          if (ofall) m_pend = 1;
          else if (m_ce) m_pend = 0;
        end
        nq.push_front(i_NMI_SRC_N);
        if (nq.size() > S) void'(nq.pop_back());
        nl = (nq.size() == S) ? nq[S-1] : 1'b1;
        iq.push_front(i_IRQ_SRC_N);
        if (iq.size() > S) void'(iq.pop_back());
        il = (iq.size() == S) ? iq[S-1] : 1'b1;
        nprev = onl;
      end
    end
  end

  task automatic test_reset();
    i_RST_N = 1'b0; i_NMI_SRC_N = 1'b1; i_IRQ_SRC_N = 1'b1;
    i_CPU_ADDR = 16'h0000; i_CPU_DATA = 8'h00; i_CPU_R_WN = 1'b0;
    repeat (3) @(negedge i_CLK);
    #1;
    checks++; if (o_CPU_CE !== 1'b0) $display("FAIL reset_ce got=%b exp=0", o_CPU_CE); else passes++;
    checks++; if (o_CPU_RST_N !== 1'b0) $display("FAIL reset_cpu_rst got=%b exp=0", o_CPU_RST_N); else passes++;
    checks++; if (o_NMI_N !== 1'b1) $display("FAIL reset_nmi got=%b exp=1", o_NMI_N); else passes++;
    checks++; if (o_IRQ_N !== 1'b1) $display("FAIL reset_irq got=%b exp=1", o_IRQ_N); else passes++;
    checks++; if (o_CPU_DATA !== 8'h00) $display("FAIL reset_data got=%h exp=00", o_CPU_DATA); else passes++;
    checks++; if (o_MEM_W_N !== 1'b1) $display("FAIL reset_wn got=%b exp=1", o_MEM_W_N); else passes++;
    i_CPU_R_WN = 1'b1;
  endtask

  task automatic test_divider(input string tag);
    int first_ce = -1;
    int rst_rise = -1;
    int ce_cnt = 0;
    @(negedge i_CLK);
    i_RST_N = 1'b1;
    for (int cyc = 1; cyc <= D * H + 2 * D; cyc++) begin
      @(negedge i_CLK); #1;
      checks++; if (o_CPU_CE !== m_ce) $display("FAIL %s_ce cyc=%0d got=%b exp=%b", tag, cyc, o_CPU_CE, m_ce); else passes++;
      checks++; if (o_CPU_RST_N !== m_rst) $display("FAIL %s_cpu_rst cyc=%0d got=%b exp=%b", tag, cyc, o_CPU_RST_N, m_rst); else passes++;
      if (o_CPU_CE === 1'b1) begin
        ce_cnt++;
        if (first_ce < 0) first_ce = cyc;
      end
      if (o_CPU_RST_N === 1'b1 && rst_rise < 0) rst_rise = cyc;
    end
    checks++; if (first_ce != D) $display("FAIL %s_first_ce got=%0d exp=%0d", tag, first_ce, D); else passes++;
    checks++; if (rst_rise != D * H) $display("FAIL %s_rst_rise got=%0d exp=%0d", tag, rst_rise, D * H); else passes++;
    checks++; if (ce_cnt != H + 2) $display("FAIL %s_ce_count got=%0d exp=%0d", tag, ce_cnt, H + 2); else passes++;
  endtask

  task automatic test_reset_abort();
    repeat (17) @(negedge i_CLK);
    #2 i_RST_N = 1'b0;
    #1;
    checks++; if (o_CPU_RST_N !== 1'b0) $display("FAIL abort_cpu_rst got=%b exp=0", o_CPU_RST_N); else passes++;
    checks++; if (o_CPU_CE !== 1'b0) $display("FAIL abort_ce got=%b exp=0", o_CPU_CE); else passes++;
    checks++; if (o_CPU_DATA !== 8'h00) $display("FAIL abort_data got=%h exp=00", o_CPU_DATA); else passes++;
    repeat (2) @(negedge i_CLK);
    test_divider("restart");
  endtask

  task automatic test_int_during_stretch();
    @(negedge i_CLK);
    i_RST_N = 1'b0; i_NMI_SRC_N = 1'b0; i_IRQ_SRC_N = 1'b0;
    @(negedge i_CLK);
    i_RST_N = 1'b1;
    for (int cyc = 1; cyc <= D * H + 2 * D; cyc++) begin
      @(negedge i_CLK); #1;
      if (o_CPU_RST_N === 1'b0) begin
        checks++; if (o_NMI_N !== 1'b1) $display("FAIL stretch_nmi cyc=%0d got=%b exp=1", cyc, o_NMI_N); else passes++;
        checks++; if (o_IRQ_N !== 1'b1) $display("FAIL stretch_irq cyc=%0d got=%b exp=1", cyc, o_IRQ_N); else passes++;
      end else begin
        checks++; if (o_NMI_N !== m_nmi) $display("FAIL stretch_run_nmi cyc=%0d got=%b exp=%b", cyc, o_NMI_N, m_nmi); else passes++;
        checks++; if (o_IRQ_N !== m_irq) $display("FAIL stretch_run_irq cyc=%0d got=%b exp=%b", cyc, o_IRQ_N, m_irq); else passes++;
      end
    end
    checks++; if (o_IRQ_N !== 1'b0) $display("FAIL stretch_irq_after got=%b exp=0", o_IRQ_N); else passes++;
    checks++; if (o_NMI_N !== 1'b0) $display("FAIL stretch_nmi_after got=%b exp=0", o_NMI_N); else passes++;
    i_NMI_SRC_N = 1'b1; i_IRQ_SRC_N = 1'b1;
    repeat (3 * D) @(negedge i_CLK);
    #1;
    checks++; if (o_NMI_N !== 1'b1) $display("FAIL stretch_nmi_idle got=%b exp=1", o_NMI_N); else passes++;
    checks++; if (o_IRQ_N !== 1'b1) $display("FAIL stretch_irq_idle got=%b exp=1", o_IRQ_N); else passes++;
  endtask

  task automatic test_nmi_pulse();
    int low_cnt = 0;
    bit started = 0;
    bit start_on_ce = 0;
    for (int i = 0; i < 2 * D; i++) begin
      @(negedge i_CLK);
      if ((k % D) == 3) break;
    end
    i_NMI_SRC_N = 1'b0;
    @(negedge i_CLK);
    i_NMI_SRC_N = 1'b1;
    for (int i = 0; i < 5 * D; i++) begin
      #1;
      checks++; if (o_NMI_N !== m_nmi) $display("FAIL nmi_model i=%0d got=%b exp=%b", i, o_NMI_N, m_nmi); else passes++;
      if (o_NMI_N === 1'b0) begin
        if (!started) start_on_ce = (o_CPU_CE === 1'b1);
        started = 1;
        low_cnt++;
      end
      @(negedge i_CLK);
    end
    checks++; if (low_cnt != D) $display("FAIL nmi_low_len got=%0d exp=%0d", low_cnt, D); else passes++;
    checks++; if (start_on_ce !== 1'b1) $display("FAIL nmi_start_on_ce got=%b exp=1", start_on_ce); else passes++;
  endtask

  task automatic test_irq_level();
    int low_cnt = 0;
    bit prev_irq;
    for (int i = 0; i < 2 * D; i++) begin
      @(negedge i_CLK);
      if ((k % D) == 5) break;
    end
    i_IRQ_SRC_N = 1'b0;
    prev_irq = o_IRQ_N;
    for (int i = 0; i < 6 * D; i++) begin
      if (i == 30) i_IRQ_SRC_N = 1'b1;
      #1;
      checks++; if (o_IRQ_N !== m_irq) $display("FAIL irq_model i=%0d got=%b exp=%b", i, o_IRQ_N, m_irq); else passes++;
      if (o_IRQ_N !== prev_irq && o_CPU_CE !== 1'b1) begin
        checks++; $display("FAIL irq_off_ce i=%0d got=%b exp=%b", i, o_IRQ_N, prev_irq);
      end
      if (o_IRQ_N === 1'b0) low_cnt++;
      prev_irq = o_IRQ_N;
      @(negedge i_CLK);
    end
    checks++; if (low_cnt != 3 * D) $display("FAIL irq_low_len got=%0d exp=%0d", low_cnt, 3 * D); else passes++;
    checks++; if (o_IRQ_N !== 1'b1) $display("FAIL irq_return got=%b exp=1", o_IRQ_N); else passes++;
  endtask

  task automatic test_bus_write_read();
    bit found = 0;
    bit wrote = 0;
    for (int i = 0; i < 2 * D; i++) begin
      @(negedge i_CLK); #1;
      if (m_ce) begin found = 1; break; end
    end
    checks++; if (!found) $display("FAIL bus_wait_ce got=timeout exp=ce"); else passes++;
    @(negedge i_CLK);
    i_CPU_ADDR = 16'h0200; i_CPU_DATA = 8'hA5; i_CPU_R_WN = 1'b0;
    for (int i = 0; i < D; i++) begin
      #1;
      checks++; if (o_MEM_W_N !== !m_ce) $display("FAIL bus_write_wn i=%0d got=%b exp=%b", i, o_MEM_W_N, !m_ce); else passes++;
      checks++; if (o_MEM_ADDR !== 16'h0200 || o_MEM_DATA !== 8'hA5) $display("FAIL bus_write_pass got=%h/%h exp=0200/a5", o_MEM_ADDR, o_MEM_DATA); else passes++;
      if (m_ce) begin wrote = 1; break; end
      @(negedge i_CLK);
    end
    checks++; if (!wrote) $display("FAIL bus_write_ce got=none exp=strobe"); else passes++;
    @(negedge i_CLK);
    i_CPU_R_WN = 1'b1; i_CPU_DATA = 8'h00;
    for (int i = 0; i < D; i++) begin
      #1;
      checks++; if (o_MEM_W_N !== 1'b1) $display("FAIL bus_read_wn i=%0d got=%b exp=1", i, o_MEM_W_N); else passes++;
      if (m_ce) break;
      @(negedge i_CLK);
    end
    checks++; if (o_CPU_DATA !== 8'hA5) $display("FAIL bus_read_data got=%h exp=a5", o_CPU_DATA); else passes++;
    @(negedge i_CLK); #1;
    checks++; if (o_CPU_DATA !== 8'hA5) $display("FAIL bus_read_hold got=%h exp=a5", o_CPU_DATA); else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge i_CLK);
      i_NMI_SRC_N = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 31) == 0) i_IRQ_SRC_N = ~i_IRQ_SRC_N;
      i_CPU_ADDR  = 16'h0200 + 16'($urandom_range(0, 15));
      i_CPU_DATA  = 8'($urandom);
      i_CPU_R_WN  = 1'($urandom);
      #1;
      checks++; if (o_CPU_CE !== m_ce) $display("FAIL rnd_ce i=%0d got=%b exp=%b", i, o_CPU_CE, m_ce); else passes++;
      checks++; if (o_CPU_RST_N !== m_rst) $display("FAIL rnd_cpu_rst i=%0d got=%b exp=%b", i, o_CPU_RST_N, m_rst); else passes++;
      checks++; if (o_NMI_N !== m_nmi) $display("FAIL rnd_nmi i=%0d got=%b exp=%b", i, o_NMI_N, m_nmi); else passes++;
      checks++; if (o_IRQ_N !== m_irq) $display("FAIL rnd_irq i=%0d got=%b exp=%b", i, o_IRQ_N, m_irq); else passes++;
      checks++; if (o_CPU_DATA !== m_data) $display("FAIL rnd_data i=%0d got=%h exp=%h", i, o_CPU_DATA, m_data); else passes++;
      checks++; if (o_MEM_W_N !== !(!i_CPU_R_WN && m_ce && m_rst)) $display("FAIL rnd_wn i=%0d got=%b exp=%b", i, o_MEM_W_N, !(!i_CPU_R_WN && m_ce && m_rst)); else passes++;
      checks++; if (o_MEM_ADDR !== i_CPU_ADDR) $display("FAIL rnd_addr i=%0d got=%h exp=%h", i, o_MEM_ADDR, i_CPU_ADDR); else passes++;
      checks++; if (o_MEM_DATA !== i_CPU_DATA) $display("FAIL rnd_wdata i=%0d got=%h exp=%h", i, o_MEM_DATA, i_CPU_DATA); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_divider("divider");
    test_reset_abort();
    test_int_during_stretch();
    test_nmi_pulse();
    test_irq_level();
    test_bus_write_read();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
